mc_port_arbiter: RTL and testbench

- Shares the single mc_top native memory port between NUM_PORTS requesters, such as a CPU cache and a DMA engine.
- Arbitrates between requesters round-robin and forwards the winner's read or write command downstream.
- Records the winning port ID in an in-order tag FIFO, so each mem_ack and its rddata are routed back to the port that issued the command.
- Sits between the requesters and mc_top, in the same clk_i domain as the controller.

---
 rtl/mc_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mc_port_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_port_arbiter.sv
// -----------------------------------------------------------------------------
// mc_port_arbiter
// Shares the single native memory port of mc_top between NUM_PORTS requesters.
// A round-robin arbiter picks one requester and forwards its read or write
// command downstream with no added latency. The winning port ID is pushed into
// an in-order tag FIFO, so every mem_ack_i and its read data are steered back
// to the port that issued the matching command.
//
// Ports:
//   clk_i          controller clock, rising edge
//   rst_i          asynchronous active-high reset
//   req_rd_i       per-port read request
//   req_wr_i       per-port 16-bit write byte mask, port p at [16p+15:16p]
//   req_addr_i     per-port address, port p at [ADDR_W*p +: ADDR_W]
//   req_wrdata_i   per-port 128-bit write data, port p at [128p +: 128]
//   req_accept_o   per-port command accepted (one-hot or zero)
//   req_ack_o      per-port response (one-hot or zero)
//   req_rddata_o   shared read data, qualified by req_ack_o
//   mem_rd_o       downstream read request
//   mem_wr_o       downstream write byte mask
//   mem_addr_o     downstream address
//   mem_wrdata_o   downstream write data
//   mem_accept_i   downstream accepts the command on mem_*
//   mem_ack_i      downstream response
//   mem_rddata_i   downstream read data
//   busy_o         at least one command is outstanding
//   err_o          sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module mc_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        req_rd_i,
  input  logic [NUM_PORTS*16-1:0]     req_wr_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS*128-1:0]    req_wrdata_i,
  output logic [NUM_PORTS-1:0]        req_accept_o,
  output logic [NUM_PORTS-1:0]        req_ack_o,
  output logic [127:0]                req_rddata_o,
  output logic                        mem_rd_o,
  output logic [15:0]                 mem_wr_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [127:0]                mem_wrdata_o,
  input  logic                        mem_accept_i,
  input  logic                        mem_ack_i,
  input  logic [127:0]                mem_rddata_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;

  // Per-port views of the flattened request buses
  logic [NUM_PORTS-1:0] w_req;
  logic [15:0]          w_port_wr     [NUM_PORTS];
  logic [ADDR_W-1:0]    w_port_addr   [NUM_PORTS];
  logic [127:0]         w_port_wrdata [NUM_PORTS];

  // Arbitration
  logic [PW-1:0] w_scan_idx;
  logic [PW-1:0] w_cand;
  logic          w_found;
  logic          w_hit;

  // Tag FIFO control
  logic          w_full;
  logic          w_empty;
  logic          w_drive;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_head;
  logic [CW-1:0] w_count_nxt;

  // State
  logic [PW-1:0] r_last_grant;
  logic          r_lock;
  logic [PW-1:0] r_lock_port;
  logic [PW-1:0] r_tag [MAX_OUTSTANDING];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_err;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_unpack
    assign w_port_wr[gp]     = req_wr_i[gp*16 +: 16];
    assign w_port_addr[gp]   = req_addr_i[gp*ADDR_W +: ADDR_W];
    assign w_port_wrdata[gp] = req_wrdata_i[gp*128 +: 128];
    assign w_req[gp]         = req_rd_i[gp] | (|req_wr_i[gp*16 +: 16]);
  end

  // Candidate selection: the stalled port while locked, otherwise the first
  // requester after last_grant in circular order.
  always_comb begin
    w_found    = 1'b0;
    w_hit      = 1'b0;
    w_cand     = r_last_grant;
    w_scan_idx = r_last_grant;
    if (r_lock) begin
      w_found = 1'b1;
      w_cand  = r_lock_port;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        // Explicit wrap so non-power-of-two port counts stay in range
        w_scan_idx = (w_scan_idx == PW'(NUM_PORTS - 1)) ? '0 : w_scan_idx + 1'b1;
        w_hit      = !w_found && w_req[w_scan_idx];
        w_cand     = w_hit ? w_scan_idx : w_cand;
        w_found    = w_found | w_hit;
      end
    end
  end

  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  // A full FIFO blocks issue even when a pop frees a slot this cycle, which
  // keeps mem_* independent of mem_ack_i.
  assign w_drive = w_found & ~w_full;
  assign w_push  = w_drive & mem_accept_i;
  assign w_pop   = mem_ack_i & ~w_empty;
  assign w_head  = r_tag[r_rd_ptr];

  // Downstream command mux and per-port accept
  always_comb begin
    mem_rd_o     = 1'b0;
    mem_wr_o     = 16'h0000;
    mem_addr_o   = '0;
    mem_wrdata_o = 128'd0;
    req_accept_o = '0;
    if (w_drive) begin
      mem_rd_o     = req_rd_i[w_cand];
      mem_wr_o     = w_port_wr[w_cand];
      mem_addr_o   = w_port_addr[w_cand];
      mem_wrdata_o = w_port_wrdata[w_cand];
      if (mem_accept_i) begin
        req_accept_o[w_cand] = 1'b1;
      end else begin
        req_accept_o = '0;
      end
    end else begin
      mem_rd_o = 1'b0;
    end
  end

  // Response routing to the port at the head of the tag FIFO
  always_comb begin
    req_ack_o    = '0;
    req_rddata_o = 128'd0;
    if (w_pop) begin
      req_ack_o[w_head] = 1'b1;
      req_rddata_o      = mem_rddata_i;
    end else begin
      req_rddata_o = 128'd0;
    end
  end

  // Next outstanding count
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Arbiter, lock and tag FIFO state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= PW'(NUM_PORTS - 1);
      r_lock       <= 1'b0;
      r_lock_port  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= w_cand;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_last_grant    <= w_cand;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);
      // Hold the stalled command's port until it is accepted
      if (w_push) begin
        r_lock <= 1'b0;
      end else if (w_drive) begin
        r_lock      <= 1'b1;
        r_lock_port <= w_cand;
      end
      if (mem_ack_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy_o = r_busy;
  assign err_o  = r_err;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mc_port_arbiter
// Directed self-checking bench for mc_port_arbiter with two ports, four tag
// FIFO entries and 32-bit addresses. Inputs change 1 ns after the rising edge;
// combinational outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mc_port_arbiter;

  localparam logic [127:0] WDATA = 128'h0000_1111_2222_3333_4444_5555_6666_7777;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [1:0]   req_rd_i;
  logic [31:0]  req_wr_i;
  logic [63:0]  req_addr_i;
  logic [255:0] req_wrdata_i;
  logic [1:0]   req_accept_o;
  logic [1:0]   req_ack_o;
  logic [127:0] req_rddata_o;
  logic         mem_rd_o;
  logic [15:0]  mem_wr_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wrdata_o;
  logic         mem_accept_i;
  logic         mem_ack_i;
  logic [127:0] mem_rddata_i;
  logic         busy_o;
  logic         err_o;

  int checks   = 0;
  int failures = 0;

  mc_port_arbiter #(
    .NUM_PORTS(2),
    .MAX_OUTSTANDING(4),
    .ADDR_W(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_rd_i(req_rd_i),
    .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i),
    .req_wrdata_i(req_wrdata_i),
    .req_accept_o(req_accept_o),
    .req_ack_o(req_ack_o),
    .req_rddata_o(req_rddata_o),
    .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o),
    .mem_wrdata_o(mem_wrdata_o),
    .mem_accept_i(mem_accept_i),
    .mem_ack_i(mem_ack_i),
    .mem_rddata_i(mem_rddata_i),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_rd_i     = 2'b00;
    req_wr_i     = 32'd0;
    req_addr_i   = 64'd0;
    req_wrdata_i = 256'd0;
    mem_accept_i = 1'b0;
    mem_ack_i    = 1'b0;
    mem_rddata_i = 128'd0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (req_accept_o !== 2'b00 || req_ack_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_req got acc=%b ack=%b exp 00/00", req_accept_o, req_ack_o);
    end
    checks++;
    if (mem_rd_o !== 1'b0 || mem_wr_o !== 16'h0000 || req_rddata_o !== 128'd0) begin
      failures++;
      $display("FAIL reset_mem got rd=%b wr=%h rdata=%h exp 0", mem_rd_o, mem_wr_o, req_rddata_o);
    end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got busy=%b err=%b exp 0/0", busy_o, err_o);
    end
    tick();
  endtask

  task automatic test_single();
    logic [127:0] store;
    do_reset();
    req_wr_i[15:0]       = 16'hFFFF;
    req_addr_i[31:0]     = 32'h0000_0000;
    req_wrdata_i[127:0]  = WDATA;
    mem_accept_i         = 1'b1;
    @(negedge clk);
    checks++;
    if (req_accept_o !== 2'b01 || mem_wr_o !== 16'hFFFF || mem_rd_o !== 1'b0) begin
      failures++;
      $display("FAIL single_wr_cmd got acc=%b wr=%h rd=%b exp 01/ffff/0", req_accept_o, mem_wr_o, mem_rd_o);
    end
    checks++;
    if (mem_wrdata_o !== WDATA || mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL single_wr_data got data=%h addr=%h exp %h/0", mem_wrdata_o, mem_addr_o, WDATA);
    end
    store = mem_wrdata_o;
    tick();
    idle();
    mem_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ack_o !== 2'b01 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_wr_ack got ack=%b busy=%b exp 01/1", req_ack_o, busy_o);
    end
    tick();
    idle();
    req_rd_i[0]  = 1'b1;
    mem_accept_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_accept_o !== 2'b01 || mem_rd_o !== 1'b1 || req_ack_o !== 2'b00) begin
      failures++;
      $display("FAIL single_rd_cmd got acc=%b rd=%b ack=%b exp 01/1/00", req_accept_o, mem_rd_o, req_ack_o);
    end
    tick();
    idle();
    mem_ack_i    = 1'b1;
    mem_rddata_i = store;
    @(negedge clk);
    checks++;
    if (req_ack_o !== 2'b01 || req_rddata_o !== WDATA) begin
      failures++;
      $display("FAIL single_rd_ack got ack=%b data=%h exp 01/%h", req_ack_o, req_rddata_o, WDATA);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got busy=%b err=%b exp 0/0", busy_o, err_o);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_acc;
    logic [1:0] exp_ack;
    do_reset();
    req_rd_i     = 2'b11;
    req_addr_i   = {32'h0000_2000, 32'h0000_1000};
    mem_accept_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem_ack_i = (k != 0);
      @(negedge clk);
      exp_acc = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_accept_o !== exp_acc) begin
        failures++;
        $display("FAIL contention_acc%0d got %b exp %b", k, req_accept_o, exp_acc);
      end
      if (k != 0) begin
        exp_ack = (k % 2 == 1) ? 2'b01 : 2'b10;
        checks++;
        if (req_ack_o !== exp_ack) begin
          failures++;
          $display("FAIL contention_ack%0d got %b exp %b", k, req_ack_o, exp_ack);
        end
      end
      tick();
    end
    idle();
    mem_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ack_o !== 2'b10) begin
      failures++;
      $display("FAIL contention_last_ack got %b exp 10", req_ack_o);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL contention_idle got busy=%b err=%b exp 0/0", busy_o, err_o);
    end
    tick();
  endtask

  task automatic test_lock();
    logic [1:0] exp_acc;
    do_reset();
    req_rd_i[1]        = 1'b1;
    req_addr_i[63:32]  = 32'h0000_0100;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        req_rd_i[0]      = 1'b1;
        req_addr_i[31:0] = 32'h0000_0200;
      end
      mem_accept_i = (k == 5);
      @(negedge clk);
      exp_acc = (k == 5) ? 2'b10 : 2'b00;
      checks++;
      if (mem_addr_o !== 32'h0000_0100 || req_accept_o !== exp_acc) begin
        failures++;
        $display("FAIL lock_cyc%0d got addr=%h acc=%b exp 00000100/%b", k, mem_addr_o, req_accept_o, exp_acc);
      end
      tick();
    end
    req_rd_i[1]  = 1'b0;
    mem_accept_i = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_addr_o !== 32'h0000_0200 || req_accept_o !== 2'b01) begin
      failures++;
      $display("FAIL lock_second got addr=%h acc=%b exp 00000200/01", mem_addr_o, req_accept_o);
    end
    tick();
    idle();
    mem_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ack_o !== 2'b10) begin
      failures++;
      $display("FAIL lock_ack1 got %b exp 10", req_ack_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (req_ack_o !== 2'b01) begin
      failures++;
      $display("FAIL lock_ack2 got %b exp 01", req_ack_o);
    end
    tick();
    idle();
  endtask

  task automatic test_full();
    int n_acc;
    n_acc = 0;
    do_reset();
    req_rd_i[0]      = 1'b1;
    req_addr_i[31:0] = 32'h0000_0040;
    mem_accept_i     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_accept_o[0] === 1'b1) begin
        n_acc++;
      end
      tick();
    end
    checks++;
    if (n_acc != 4) begin
      failures++;
      $display("FAIL full_accepts got %0d exp 4", n_acc);
    end
    checks++;
    if (busy_o !== 1'b1 || mem_rd_o !== 1'b0) begin
      failures++;
      $display("FAIL full_state got busy=%b rd=%b exp 1/0", busy_o, mem_rd_o);
    end
    mem_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_accept_o !== 2'b00 || mem_rd_o !== 1'b0 || req_ack_o !== 2'b01) begin
      failures++;
      $display("FAIL full_pop_cycle got acc=%b rd=%b ack=%b exp 00/0/01", req_accept_o, mem_rd_o, req_ack_o);
    end
    tick();
    mem_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if (req_accept_o !== 2'b01 || mem_rd_o !== 1'b1) begin
      failures++;
      $display("FAIL full_resume got acc=%b rd=%b exp 01/1", req_accept_o, mem_rd_o);
    end
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      mem_ack_i = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ack_o !== 2'b01) begin
        failures++;
        $display("FAIL full_drain%0d got %b exp 01", k, req_ack_o);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL full_idle got busy=%b err=%b exp 0/0", busy_o, err_o);
    end
    tick();
  endtask

  task automatic test_routing();
    logic [127:0] dat [4];
    logic [1:0]   ports [4];
    dat[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    dat[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    dat[2] = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    dat[3] = 128'hDDDD_0000_0000_0000_0000_0000_0000_000D;
    ports[0] = 2'b01;
    ports[1] = 2'b10;
    ports[2] = 2'b10;
    ports[3] = 2'b01;
    do_reset();
    mem_accept_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_rd_i = ports[k];
      @(negedge clk);
      checks++;
      if (req_accept_o !== ports[k]) begin
        failures++;
        $display("FAIL route_acc%0d got %b exp %b", k, req_accept_o, ports[k]);
      end
      tick();
    end
    // Fourth push coincides with the first pop
    req_rd_i     = ports[3];
    mem_ack_i    = 1'b1;
    mem_rddata_i = dat[0];
    @(negedge clk);
    checks++;
    if (req_accept_o !== 2'b01 || req_ack_o !== 2'b01 || req_rddata_o !== dat[0]) begin
      failures++;
      $display("FAIL route_pushpop got acc=%b ack=%b data=%h exp 01/01/%h", req_accept_o, req_ack_o, req_rddata_o, dat[0]);
    end
    tick();
    req_rd_i     = 2'b00;
    mem_accept_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      mem_rddata_i = dat[k];
      @(negedge clk);
      checks++;
      if (req_ack_o !== ports[k] || req_rddata_o !== dat[k] || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL route_ack%0d got ack=%b data=%h busy=%b exp %b/%h/1", k, req_ack_o, req_rddata_o, busy_o, ports[k], dat[k]);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL route_idle got busy=%b err=%b exp 0/0", busy_o, err_o);
    end
    tick();
  endtask

  task automatic test_errors();
    do_reset();
    mem_ack_i    = 1'b1;
    mem_rddata_i = 128'h1234;
    @(negedge clk);
    checks++;
    if (req_ack_o !== 2'b00) begin
      failures++;
      $display("FAIL err_no_ack got %b exp 00", req_ack_o);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky got err=%b busy=%b exp 1/0", err_o, busy_o);
    end
    tick();
    // Two outstanding commands from port 0, then a stall that locks port 1
    req_rd_i         = 2'b01;
    req_addr_i[31:0] = 32'h0000_0300;
    mem_accept_i     = 1'b1;
    tick();
    tick();
    req_rd_i          = 2'b10;
    req_addr_i[63:32] = 32'h0000_0400;
    mem_accept_i      = 1'b0;
    tick();
    req_rd_i = 2'b11;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || mem_addr_o !== 32'h0000_0400) begin
      failures++;
      $display("FAIL err_locked got busy=%b addr=%h exp 1/00000400", busy_o, mem_addr_o);
    end
    tick();
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_async_rst got busy=%b err=%b exp 0/0", busy_o, err_o);
    end
    checks++;
    if (mem_addr_o !== 32'h0000_0300 || mem_rd_o !== 1'b1) begin
      failures++;
      $display("FAIL err_lock_cleared got addr=%h rd=%b exp 00000300/1", mem_addr_o, mem_rd_o);
    end
    @(negedge clk);
    idle();
    rst_i = 1'b0;
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ack_o !== 2'b00) begin
      failures++;
      $display("FAIL err_stale_ack got %b exp 00", req_ack_o);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_after_rst got %b exp 1", err_o);
    end
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_full();
    test_routing();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
